// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encoding, direction enum, step tables and
// the own/opponent cell codes for the player to move.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_INV   = 2'b11;

    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_t;

    // Row/column step per direction, indexed by dir_t
    localparam int DR [0:7] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    localparam int DC [0:7] = '{ 0,  1, 1, 1, 0, -1, -1, -1};

    // player 0 = black, 1 = white
    function automatic logic [1:0] own_cell(input logic player);
        return player ? CELL_WHITE : CELL_BLACK;
    endfunction

    function automatic logic [1:0] opp_cell(input logic player);
        return player ? CELL_BLACK : CELL_WHITE;
    endfunction

endpackage

// File: rtl/move_validator_if.sv
// Request/result bus between the game-control FSM (master) and the move
// validator (slave).
//   start/s_addr_in/player : request from master
//   busy_o/done_o          : status from validator
//   dir_mask_o/valid_o/flip_cnt_o : result, held until the next accepted start
interface move_validator_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned FLIP_W = 6
) ();
    logic              start;
    logic [ADDR_W-1:0] s_addr_in;
    logic              player;
    logic              busy_o;
    logic              done_o;
    logic [7:0]        dir_mask_o;
    logic              valid_o;
    logic [FLIP_W-1:0] flip_cnt_o;

    modport master (
        output start, s_addr_in, player,
        input  busy_o, done_o, dir_mask_o, valid_o, flip_cnt_o
    );

    modport slave (
        input  start, s_addr_in, player,
        output busy_o, done_o, dir_mask_o, valid_o, flip_cnt_o
    );
endinterface

// File: rtl/move_validator_coord_stepper.sv
// Combinational one-cell step on the board in a given direction.
//   row/col/dir        : current coordinates and direction
//   next_row/next_col  : stepped coordinates (meaningful only when on_board)
//   on_board           : stepped cell lies inside the board
//   next_idx           : next_row*BOARD_W + next_col
module coord_stepper
    import othello_pkg::*;
#(
    parameter int unsigned BOARD_W = 8,
    parameter int unsigned BOARD_H = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned ROW_W   = $clog2(BOARD_H),
    parameter int unsigned COL_W   = $clog2(BOARD_W)
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  dir_t              dir,
    output logic [ROW_W-1:0]  next_row,
    output logic [COL_W-1:0]  next_col,
    output logic              on_board,
    output logic [ADDR_W-1:0] next_idx
);

    int nr;
    int nc;

    // Signed coordinate arithmetic so a step off either edge is detected
    always_comb begin
        nr       = int'(row) + DR[dir];
        nc       = int'(col) + DC[dir];
        on_board = (nr >= 0) && (nr < int'(BOARD_H)) && (nc >= 0) && (nc < int'(BOARD_W));
        next_row = ROW_W'(nr);
        next_col = COL_W'(nc);
        next_idx = ADDR_W'(nr * int'(BOARD_W) + nc);
    end

endmodule

// File: rtl/move_validator.sv
// Othello move validator: walks all 8 directions from a candidate cell via the
// board RAM read port and reports flanking directions and total flip count.
//   clock, reset (sync, active low)
//   ctl        : request/result bus (slave side)
//   ram_rd_o/ram_addr_o : one-cycle read strobe and address
//   ram_data_i : cell value, valid RD_LAT cycles after the strobe
module move_validator
    import othello_pkg::*;
#(
    parameter int unsigned BOARD_W = 8,
    parameter int unsigned BOARD_H = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned FLIP_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    move_validator_if.slave   ctl,
    output logic              ram_rd_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [1:0]        ram_data_i
);

    localparam int unsigned CELLS  = BOARD_W * BOARD_H;
    localparam int unsigned ROW_W  = $clog2(BOARD_H);
    localparam int unsigned COL_W  = $clog2(BOARD_W);
    localparam int unsigned WAIT_W = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {
        IDLE, ORG_RD, ORG_WAIT, STEP, RD, WAIT, EVAL, NEXT_DIR, DONE
    } state_t;

    state_t              state_q, state_n;
    logic                player_q, player_n;
    logic [ROW_W-1:0]    org_row_q, org_row_n, cur_row_q, cur_row_n;
    logic [COL_W-1:0]    org_col_q, org_col_n, cur_col_q, cur_col_n;
    dir_t                dir_q, dir_n;
    logic [FLIP_W-1:0]   run_q, run_n, acc_q, acc_n;
    logic [7:0]          mask_q, mask_n;
    logic [WAIT_W-1:0]   wait_q, wait_n;
    logic [1:0]          data_q, data_n;
    logic                ram_rd_q, ram_rd_n;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_n;
    logic                busy_q, busy_n, done_q, done_n;
    logic [7:0]          out_mask_q, out_mask_n;
    logic                out_valid_q, out_valid_n;
    logic [FLIP_W-1:0]   out_flip_q, out_flip_n;
    logic [FLIP_W:0]     acc_sum;
    logic                sat_hit;

    logic [ROW_W-1:0]    step_row;
    logic [COL_W-1:0]    step_col;
    logic                step_on;
    logic [ADDR_W-1:0]   step_idx;

    coord_stepper #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .ADDR_W  (ADDR_W)
    ) u_step (
        .row      (cur_row_q),
        .col      (cur_col_q),
        .dir      (dir_q),
        .next_row (step_row),
        .next_col (step_col),
        .on_board (step_on),
        .next_idx (step_idx)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            player_q    <= 1'b0;
            org_row_q   <= '0;
            org_col_q   <= '0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            dir_q       <= DIR_N;
            run_q       <= '0;
            acc_q       <= '0;
            mask_q      <= '0;
            wait_q      <= '0;
            data_q      <= CELL_EMPTY;
            ram_rd_q    <= 1'b0;
            ram_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
            out_flip_q  <= '0;
        end else begin
            state_q     <= state_n;
            player_q    <= player_n;
            org_row_q   <= org_row_n;
            org_col_q   <= org_col_n;
            cur_row_q   <= cur_row_n;
            cur_col_q   <= cur_col_n;
            dir_q       <= dir_n;
            run_q       <= run_n;
            acc_q       <= acc_n;
            mask_q      <= mask_n;
            wait_q      <= wait_n;
            data_q      <= data_n;
            ram_rd_q    <= ram_rd_n;
            ram_addr_q  <= ram_addr_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            out_mask_q  <= out_mask_n;
            out_valid_q <= out_valid_n;
            out_flip_q  <= out_flip_n;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_n     = state_q;
        player_n    = player_q;
        org_row_n   = org_row_q;
        org_col_n   = org_col_q;
        cur_row_n   = cur_row_q;
        cur_col_n   = cur_col_q;
        dir_n       = dir_q;
        run_n       = run_q;
        acc_n       = acc_q;
        mask_n      = mask_q;
        wait_n      = wait_q;
        data_n      = data_q;
        ram_addr_n  = ram_addr_q;
        out_mask_n  = out_mask_q;
        out_valid_n = out_valid_q;
        out_flip_n  = out_flip_q;
        done_n      = 1'b0;
        sat_hit     = 1'b0;
        acc_sum     = {1'b0, acc_q} + {1'b0, run_q};

        unique case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    player_n    = ctl.player;
                    mask_n      = '0;
                    acc_n       = '0;
                    out_mask_n  = '0;
                    out_valid_n = 1'b0;
                    out_flip_n  = '0;
                    org_row_n   = ROW_W'(ctl.s_addr_in / ADDR_W'(BOARD_W));
                    org_col_n   = COL_W'(ctl.s_addr_in % ADDR_W'(BOARD_W));
                    if (int'(ctl.s_addr_in) >= int'(CELLS)) begin
                        state_n = DONE;
                    end else begin
                        ram_addr_n = ctl.s_addr_in;
                        state_n    = ORG_RD;
                    end
                end
            end
            ORG_RD: begin
                wait_n  = '0;
                state_n = ORG_WAIT;
            end
            // Origin data is judged directly on its arrival cycle
            ORG_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    if (ram_data_i != CELL_EMPTY) begin
                        state_n = DONE;
                    end else begin
                        dir_n     = DIR_N;
                        run_n     = '0;
                        cur_row_n = org_row_q;
                        cur_col_n = org_col_q;
                        state_n   = STEP;
                    end
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            STEP: begin
                if (!step_on) begin
                    state_n = NEXT_DIR;
                end else begin
                    cur_row_n  = step_row;
                    cur_col_n  = step_col;
                    ram_addr_n = step_idx;
                    state_n    = RD;
                end
            end
            RD: begin
                wait_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    data_n  = ram_data_i;
                    state_n = EVAL;
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            // Empty, invalid, or own with no run all end the line unflanked
            EVAL: begin
                if (data_q == opp_cell(player_q)) begin
                    run_n   = run_q + FLIP_W'(1);
                    state_n = STEP;
                end else begin
                    if (data_q == own_cell(player_q) && run_q != '0) begin
                        mask_n[dir_q] = 1'b1;
                        if (acc_sum[FLIP_W]) begin
                            acc_n   = '1;
                            sat_hit = 1'b1;
                        end else begin
                            acc_n = acc_sum[FLIP_W-1:0];
                        end
                    end
                    state_n = NEXT_DIR;
                end
            end
            NEXT_DIR: begin
                if (dir_q == DIR_NW) begin
                    state_n = DONE;
                end else begin
                    dir_n     = dir_t'(dir_q + 3'd1);
                    run_n     = '0;
                    cur_row_n = org_row_q;
                    cur_col_n = org_col_q;
                    state_n   = STEP;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Results become visible together with the done pulse
        if (state_n == DONE) begin
            done_n      = 1'b1;
            out_mask_n  = mask_n;
            out_valid_n = |mask_n;
            out_flip_n  = acc_n;
        end
        ram_rd_n = (state_n == ORG_RD) || (state_n == RD);
        busy_n   = (state_n != IDLE);
    end

    // Flip accumulator must never reach saturation with legal parameters
    assert property (@(posedge clock) disable iff (!reset) !sat_hit);

    assign ram_rd_o       = ram_rd_q;
    assign ram_addr_o     = ram_addr_q;
    assign ctl.busy_o     = busy_q;
    assign ctl.done_o     = done_q;
    assign ctl.dir_mask_o = out_mask_q;
    assign ctl.valid_o    = out_valid_q;
    assign ctl.flip_cnt_o = out_flip_q;

endmodule
